// File: rtl/alu_acc.sv
// Accumulator ALU: single-cycle arithmetic/logic ops plus an optional shift-add multiplier.
// Define ALU_ACC_MUL_EN to build in MUL (op 8); otherwise op 8 is treated as illegal.
module alu_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] acc_reg;
    logic [3:0]       flags_reg;
    logic             done_reg;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum_ext;
    logic             alu_c;
    logic             alu_v;
    logic             alu_legal;
    logic             accept;

    assign accept = start && !busy;
    assign acc    = acc_reg;
    assign flags  = flags_reg;
    assign done   = done_reg;

    always_comb begin
        alu_res   = '0;
        sum_ext   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (op)
            4'd0: alu_res = b;
            4'd1: begin
                sum_ext = {1'b0, acc_reg} + {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (acc_reg[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != acc_reg[WIDTH-1]);
            end
            4'd2: begin
                // Top bit of the extended difference is the borrow (acc < b unsigned)
                sum_ext = {1'b0, acc_reg} - {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (acc_reg[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != acc_reg[WIDTH-1]);
            end
            4'd3: alu_res = acc_reg & b;
            4'd4: alu_res = acc_reg | b;
            4'd5: alu_res = acc_reg ^ b;
            4'd6: begin
                alu_res = {acc_reg[WIDTH-2:0], 1'b0};
                alu_c   = acc_reg[WIDTH-1];
            end
            4'd7: begin
                alu_res = {1'b0, acc_reg[WIDTH-1:1]};
                alu_c   = acc_reg[0];
            end
            default: alu_legal = 1'b0;
        endcase
    end

`ifdef ALU_ACC_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t state_reg, state_next;

    logic [2*WIDTH-1:0] prod_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] mul_sum;
    logic               mul_last;
    logic               start_mul;

    assign start_mul = accept && (op == 4'd8);
    assign mul_sum   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_last  = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_mul) state_next = MUL_RUN;
            MUL_RUN: if (mul_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == MUL_RUN);
    end

    // One multiplier bit per cycle; the multiplicand walks left as the multiplier walks right
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (start_mul) begin
            prod_reg   <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, acc_reg};
            mplier_reg <= b;
            count_reg  <= '0;
        end else if (state_reg == MUL_RUN) begin
            prod_reg   <= mul_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= mul_last ? '0 : count_reg + 1'b1;
        end
    end
`else
    logic start_mul;
    assign start_mul = 1'b0;
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            flags_reg <= 4'b0100;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                if (alu_legal) begin
                    acc_reg   <= alu_res;
                    flags_reg <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                end
                // A multiply reports completion only after its final iteration
                done_reg <= !start_mul;
            end
`ifdef ALU_ACC_MUL_EN
            else if (state_reg == MUL_RUN && mul_last) begin
                acc_reg   <= mul_sum[WIDTH-1:0];
                flags_reg <= {mul_sum[WIDTH-1], (mul_sum[WIDTH-1:0] == '0),
                              (mul_sum[2*WIDTH-1:WIDTH] != '0), 1'b0};
                done_reg  <= 1'b1;
            end
`endif
        end
    end

endmodule
